// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART transmit arbiter.
// Optional macro UART_ARB_HDR_EN adds the header state.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam logic [7:0]  HDR_TAG     = 8'hA0;

`ifdef UART_ARB_HDR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HDR  = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1
  } arb_state_e;
`endif

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_grant+1, wrapping.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest active requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % int'(N_REQ));
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter multiplexing per-requester byte frames onto one UART transmitter.
// Optional macro UART_ARB_HDR_EN prefixes each grant with a tag byte HDR_TAG|grant_id.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = UART_DATA_W,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned GNT_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [GNT_W-1:0]        grant_id,
  output logic                    busy
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e       state, state_nxt;
  logic [GNT_W-1:0] last_grant, last_grant_nxt, grant_nxt;
  logic [7:0]       burst_cnt, burst_cnt_nxt;
  logic             pick_found;
  logic [GNT_W-1:0] pick_idx;
  logic             sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (GNT_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[32'(grant_id) * DATA_W +: DATA_W];
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GNT_W'(N_REQ - 1);
      grant_id   <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Next state and the combinational data path toward the transmitter.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant_id;
    burst_cnt_nxt  = burst_cnt;
    out_valid      = 1'b0;
    out_data       = '0;
    req_ready      = '0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
`ifdef UART_ARB_HDR_EN
          state_nxt = ST_HDR;
`else
          state_nxt = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = DATA_W'(HDR_TAG) | DATA_W'(grant_id);
        if (out_ready) state_nxt = ST_XFER;
      end
`endif
      ST_XFER: begin
        out_valid           = sel_valid;
        out_data            = sel_data;
        req_ready[grant_id] = out_ready;
        if (sel_valid && out_ready) begin
          // A frame cut at the burst limit resumes on its requester's next win.
          if (sel_last || (burst_cnt == BURST_LAST)) begin
            state_nxt      = ST_IDLE;
            last_grant_nxt = grant_id;
            burst_cnt_nxt  = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a queue-based frame model.
// Header-byte expectations follow UART_ARB_HDR_EN when defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 16;
  localparam int unsigned GW = 2;
  localparam int          QD = 256;
`ifdef UART_ARB_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_ready, busy;
  logic [DW-1:0]   out_data;
  logic [GW-1:0]   grant_id;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-requester byte queues {last, data}; head/tail grow monotonically.
  logic [8:0] fifo [N][QD];
  int hd [N];
  int tl [N];
  int valid_pct, ready_pct, pushed;

  // Frame-level model: idle (0), header (1), streaming (2).
  int m_phase, m_gid, m_last, m_cnt;
  int log_id [2048];
  int log_dat [2048];
  int log_n;
  int hdr_dat [1024];
  int hdr_n;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic mreset();
    m_phase = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
    for (int r = 0; r < N; r++) begin hd[r] = 0; tl[r] = 0; end
  endtask

  task automatic push_frame(input int r, input int len, input int base, input int stride);
    for (int i = 0; i < len; i++) begin
      fifo[r][tl[r] % QD] = {(i == len - 1), (base < 0) ? 8'($urandom) : 8'(base + i * stride)};
      tl[r]++;
      pushed++;
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (hd[r] != tl[r] && int'($urandom_range(99)) < valid_pct) begin
        req_valid[r]          = 1'b1;
        req_data[r*DW +: DW]  = fifo[r][hd[r] % QD][7:0];
        req_last[r]           = fifo[r][hd[r] % QD][8];
      end else begin
        req_valid[r]          = 1'b0;
        req_data[r*DW +: DW]  = 8'($urandom);
        req_last[r]           = 1'($urandom);
      end
    end
    out_ready = int'($urandom_range(99)) < ready_pct;
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic eval_cycle();
    logic          eov;
    logic [DW-1:0] eod;
    logic [N-1:0]  err;
    logic [8:0]    head;
    int            w, c;
    if (!rst_n) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      return;
    end
    eov = 1'b0; eod = '0; err = '0; head = '0;
    if (m_phase == 2) begin
      head = fifo[m_gid][hd[m_gid] % QD];
      eov = req_valid[GW'(m_gid)];
      eod = head[7:0];
      err[GW'(m_gid)] = out_ready;
    end else if (m_phase == 1) begin
      eov = 1'b1;
      eod = 8'hA0 | 8'(m_gid);
    end
    chk("out_valid", int'(out_valid), int'(eov));
    chk("req_ready", int'(req_ready), int'(err));
    chk("busy", int'(busy), int'(m_phase != 0));
    if (eov) chk("out_data", int'(out_data), int'(eod));
    if (m_phase != 0) chk("grant_id", int'(grant_id), m_gid);

    if (m_phase == 0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (w < 0 && req_valid[GW'(c)]) w = c;
      end
      if (w >= 0) begin m_gid = w; m_phase = HDR_ON ? 1 : 2; end
    end else if (m_phase == 1) begin
      if (out_ready) begin
        if (hdr_n < 1024) begin hdr_dat[hdr_n] = int'(eod); hdr_n++; end
        m_phase = 2;
      end
    end else if (req_valid[GW'(m_gid)] && out_ready) begin
      if (log_n < 2048) begin log_id[log_n] = m_gid; log_dat[log_n] = int'(head[7:0]); log_n++; end
      hd[m_gid]++;
      m_cnt++;
      if (head[8] || m_cnt == MB) begin m_phase = 0; m_last = m_gid; m_cnt = 0; end
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    log_n = 0; hdr_n = 0; pushed = 0;
    valid_pct = 100; ready_pct = 100;
    drive();
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_n < n; i++) step();
    chk("wait_log", log_n, n);
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < N; r++) if (hd[r] != tl[r]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ord [8];
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n = 1'b0; out_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    valid_pct = 100; ready_pct = 100; pushed = 0;
    mreset();
    #3;

    // Single requester, three-byte frame.
    do_reset();
    push_frame(1, 3, 8'h11, 8'h11);
    drive();
    run(10);
    chk("t1_count", log_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_id", log_id[i], 1);
      chk("t1_data", log_dat[i], 8'h11 * (i + 1));
    end

    // All requesters with back-to-back one-byte frames.
    do_reset();
    for (int r = 0; r < N; r++) begin
      push_frame(r, 1, 8'h80 + r, 1);
      push_frame(r, 1, 8'h90 + r, 1);
    end
    drive();
    run(30);
    chk("t2_count", log_n, 8);
    for (int i = 0; i < 8; i++) chk("t2_order", log_id[i], ord[i]);

    // Twenty-byte frame truncated at the burst limit.
    do_reset();
    push_frame(2, 20, 8'h40, 1);
    push_frame(3, 1, 8'hC0, 1);
    drive();
    run(50);
    chk("t3_count", log_n, 21);
    for (int i = 0; i < 16; i++) begin
      chk("t3_first_id", log_id[i], 2);
      chk("t3_first_data", log_dat[i], 8'h40 + i);
    end
    chk("t3_rearb_id", log_id[16], 3);
    for (int i = 17; i < 21; i++) begin
      chk("t3_rest_id", log_id[i], 2);
      chk("t3_rest_data", log_dat[i], 8'h40 + i - 1);
    end

    // Transmitter stall mid-frame.
    do_reset();
    push_frame(0, 6, 8'h60, 1);
    drive();
    run(3);
    ready_pct = 0; drive();
    run(5);
    ready_pct = 100; drive();
    run(12);
    chk("t4_count", log_n, 6);
    for (int i = 0; i < 6; i++) chk("t4_data", log_dat[i], 8'h60 + i);

    // Reset in the middle of a frame.
    do_reset();
    push_frame(2, 4, 8'h50, 1);
    drive();
    wait_log(2, 20);
    rst_n = 1'b0;
    mreset();
    #1;
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_req_ready", int'(req_ready), 0);
    chk("t5_rst_busy", int'(busy), 0);
    drive();
    run(2);
    rst_n = 1'b1;
    base = log_n;
    push_frame(2, 2, 8'h58, 1);
    push_frame(0, 1, 8'h70, 1);
    drive();
    run(12);
    chk("t5_count", log_n - base, 3);
    chk("t5_first_id", log_id[base], 0);
    chk("t5_first_data", log_dat[base], 8'h70);

`ifdef UART_ARB_HDR_EN
    // Header byte ahead of the payload.
    do_reset();
    push_frame(3, 1, 8'h55, 1);
    drive();
    run(6);
    chk("t6_hdr_count", hdr_n, 1);
    chk("t6_hdr_byte", hdr_dat[0], 8'hA3);
    chk("t6_count", log_n, 1);
    chk("t6_data", log_dat[0], 8'h55);
`endif

    // Random traffic with flapping valid and ready.
    do_reset();
    valid_pct = 70; ready_pct = 70;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 100 == 0)
        for (int r = 0; r < N; r++)
          if (tl[r] - hd[r] < 20) push_frame(r, int'($urandom_range(24, 1)), -1, 1);
      step();
    end
    valid_pct = 100; ready_pct = 100;
    for (int i = 0; i < 3000 && !(all_empty() && m_phase == 0); i++) step();
    chk("rand_drained", log_n, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..16.
REQ-002 Parameter DATA_W, default 8: byte width of data.
REQ-003 Parameter MAX_BURST, default 16: maximum bytes accepted per grant, range 1..255.
REQ-004 clk  in  1: single clock; all state on posedge clk.
REQ-005 rst_n  in  1: asynchronous active-low reset.
REQ-006 req_valid  in  N_REQ: per-requester byte valid.
REQ-007 req_data  in  N_REQ x DATA_W: per-requester byte.
REQ-008 req_last  in  N_REQ: marks the final byte of a requester's frame.
REQ-009 req_ready  out  N_REQ: per-requester accept.
REQ-010 out_valid  out  1: byte offered to the UART transmitter.
REQ-011 out_data  out  DATA_W: byte offered to the UART transmitter.
REQ-012 out_ready  in  1: UART transmitter accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-013 grant_id  out  clog2(N_REQ): currently granted requester.
REQ-014 busy  out  1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, HDR (present only with the macro) and XFER.
REQ-016 In IDLE with any req_valid high, the block SHALL register a round-robin winner and enter HDR or XFER next cycle; first out_valid is 1 cycle after the winning req_valid.
REQ-017 Round-robin: search SHALL start at (last_grant+1) mod N_REQ and wrap; with a single active requester it SHALL win repeatedly.
REQ-018 In XFER, out_valid, out_data and req_ready[grant_id] SHALL be combinational pass-throughs of req_valid[grant_id], req_data[grant_id] and out_ready.
REQ-019 In XFER, all other req_ready bits SHALL be 0; in IDLE and HDR, all req_ready bits SHALL be 0.
REQ-020 A burst counter (8 bit) SHALL increment on each XFER transfer.
REQ-021 A transfer with req_last=1, or the MAX_BURST-th transfer, SHALL return the FSM to IDLE and update last_grant; the counter SHALL clear.
REQ-022 If the granted requester drops req_valid mid-frame, the block SHALL hold the grant with out_valid=0 (no timeout).
REQ-023 Requests arriving while busy SHALL be ignored until the FSM returns to IDLE.
REQ-024 grant_id SHALL be stable from grant until return to IDLE.
REQ-025 A frame truncated by MAX_BURST SHALL resume as a new grant when the requester next wins.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first), counter=0, grant_id=0.
REQ-027 During and after reset until the next grant: out_valid=0, req_ready=0, busy=0.
REQ-028 Reset mid-frame SHALL drop the frame with no further output byte.

Configuration
REQ-029 Macro UART_ARB_HDR_EN defined: after each grant, state HDR SHALL drive out_valid=1, out_data=HDR_TAG|grant_id and hold until out_ready, then enter XFER.
REQ-030 Header bytes SHALL NOT count toward MAX_BURST.
REQ-031 UART_ARB_HDR_EN undefined: HDR state and its logic SHALL be absent, and grant SHALL go directly to XFER.

Structure
REQ-032 Package uart_pkg SHALL hold UART_DATA_W=8, HDR_TAG=8'hA0 and the arbiter state enum type.
REQ-033 Sub-module uart_rr_pick SHALL provide the combinational round-robin winner (inputs req vector and last_grant; outputs found and idx).

Verification
REQ-034 Single requester 1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_data sequence 0x11,0x22,0x33; grant_id=1; busy drops the cycle after 0x33.
REQ-035 All 4 requesters hold 1-byte frames continuously -> grant order 0,1,2,3,0.
REQ-036 Requester 2 sends a 20-byte frame with MAX_BURST=16 -> 16 bytes sent, then re-arbitration, then the remaining 4 bytes.
REQ-037 out_ready held low for 5 cycles mid-frame -> out_data stable and no byte lost or duplicated.
REQ-038 With UART_ARB_HDR_EN, requester 3 frame 0x55 -> output 0xA3 then 0x55.
REQ-039 rst_n pulsed low after the 2nd byte of a 4-byte frame -> out_valid=0 immediately; next grant goes to requester 0.
